vectorsum_stream_out: RTL and testbench

- Downstream drain stage for vectorsum_top. On start, which is wired to vectorsum_top done, it walks the z result memory from address 0 to VECTOR_SIZE-1.
- Read port has registered 1-cycle latency. Each word is emitted on a valid/ready stream with a last flag.
- Handles consumer backpressure without losing or duplicating words, using a 2-entry output buffer and read-issue credit logic.

---
 rtl/vectorsum_pkg.sv | 27 ++
 rtl/vectorsum_stream_out_fifo.sv | 93 +++++++++
 rtl/vectorsum_stream_out.sv | 127 ++++++++++++
 tb/tb_vectorsum_stream_out.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vectorsum_pkg.sv
// Shared definitions for the vectorsum result drain stage: default sizes,
// drain FSM state type and the read-issue credit rule.
package vectorsum_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 10;
  localparam int DEF_VECTOR_SIZE = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } stream_state_t;

  // A new read may be issued only if the words already buffered plus the one
  // still coming back from memory, minus the one leaving this cycle, leave
  // room in the 2-entry output buffer.
  function automatic logic credit_ok(input logic [1:0] occ,
                                     input logic       inflight,
                                     input logic       pop);
    logic [2:0] pending;
    pending = {1'b0, occ} + {2'b00, inflight};
    return (pending < (3'd2 + {2'b00, pop}));
  endfunction

endpackage

// File: rtl/vectorsum_stream_out_fifo.sv
// Two-entry first-word-fall-through buffer. entry0 is always the head, so the
// head is visible the cycle after it is pushed. Push and pop together are
// accepted at any occupancy; illegal requests are ignored and flagged by the
// companion checker.
module stream_fifo2 #(
  parameter int WIDTH = 33
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       occ
);

  logic [WIDTH-1:0] entry0_r;
  logic [WIDTH-1:0] entry1_r;
  logic [1:0]       occ_r;
  logic             pop_s;
  logic             push_s;

  assign head_data = entry0_r;
  assign occ       = occ_r;

  // Qualify requests so an illegal pop or overflowing push cannot corrupt state.
  always_comb begin
    pop_s  = pop && (occ_r != 2'd0);
    push_s = push && ((occ_r != 2'd2) || pop_s);
  end

  // Storage and occupancy update.
  always_ff @(posedge clock) begin
    if (reset) begin
      entry0_r <= {WIDTH{1'b0}};
      entry1_r <= {WIDTH{1'b0}};
      occ_r    <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (occ_r == 2'd0) begin
            entry0_r <= push_data;
          end else begin
            entry1_r <= push_data;
          end
          occ_r <= occ_r + 2'd1;
        end
        2'b01: begin
          entry0_r <= entry1_r;
          occ_r    <= occ_r - 2'd1;
        end
        2'b11: begin
          if (occ_r == 2'd1) begin
            entry0_r <= push_data;
          end else begin
            entry0_r <= entry1_r;
            entry1_r <= push_data;
          end
        end
        default: begin
          occ_r <= occ_r;
        end
      endcase
    end
  end

  stream_fifo2_chk u_chk (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .occ   (occ_r)
  );

endmodule

// Protocol checker for stream_fifo2: the credit logic upstream must never
// push into a full buffer without a matching pop, nor pop an empty one.
module stream_fifo2_chk (
  input logic       clock,
  input logic       reset,
  input logic       push,
  input logic       pop,
  input logic [1:0] occ
);

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push && !pop && (occ == 2'd2)));

  a_no_underflow: assert property (@(posedge clock) disable iff (reset)
    !(pop && (occ == 2'd0)));

endmodule

// File: rtl/vectorsum_stream_out.sv
// Drain stage for vectorsum_top: on start, reads z[0..VECTOR_SIZE-1] through
// a 1-cycle registered read port and emits each word on a valid/ready stream,
// tagging the final word with out_last. Reads are throttled by a credit rule
// so the 2-entry output buffer never overflows under backpressure.
module vectorsum_stream_out
  import vectorsum_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int VECTOR_SIZE = DEF_VECTOR_SIZE
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VECTOR_SIZE - 1);

  stream_state_t         state_r;
  stream_state_t         state_next_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  inflight_r;
  logic                  last_tag_r;
  logic                  busy_r;
  logic                  done_r;
  logic [1:0]            occ_s;
  logic [DATA_WIDTH:0]   head_s;
  logic                  valid_s;
  logic                  pop_s;
  logic                  issue_s;

  assign mem_rd_addr = addr_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign out_valid   = valid_s;
  assign out_data    = head_s[DATA_WIDTH-1:0];
  assign out_last    = head_s[DATA_WIDTH];

  // Stream handshake decode from the buffer state.
  always_comb begin
    valid_s = (occ_s != 2'd0);
    pop_s   = valid_s && out_ready;
  end

  // Next-state and read-issue decision.
  always_comb begin
    state_next_s = state_r;
    issue_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = STREAM;
        end else begin
          state_next_s = IDLE;
        end
      end
      STREAM: begin
        issue_s = credit_ok(occ_s, inflight_r, pop_s);
        if (issue_s && (addr_r == LAST_ADDR)) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = STREAM;
        end
      end
      DRAIN: begin
        if (pop_s && out_last) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, address counter, in-flight tracking and registered status flags.
  // The counter parks on the final address instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      addr_r     <= {ADDR_WIDTH{1'b0}};
      inflight_r <= 1'b0;
      last_tag_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (state_next_s == IDLE) begin
        addr_r <= {ADDR_WIDTH{1'b0}};
      end else if (issue_s && (addr_r != LAST_ADDR)) begin
        addr_r <= addr_r + ADDR_WIDTH'(1);
      end else begin
        addr_r <= addr_r;
      end
      inflight_r <= issue_s;
      last_tag_r <= issue_s && (addr_r == LAST_ADDR);
      busy_r     <= (state_next_s == STREAM) || (state_next_s == DRAIN);
      done_r     <= (state_next_s == DONE);
    end
  end

  stream_fifo2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight_r),
    .push_data ({last_tag_r, mem_dout}),
    .pop       (pop_s),
    .head_data (head_s),
    .occ       (occ_s)
  );

endmodule

// File: tb/tb_vectorsum_stream_out.sv
// Self-checking bench for vectorsum_stream_out: a 64-word instance and a
// 1-word instance, each fed by a registered-read memory model. Expected beats
// are simply z[0..N-1] in order with last on the final one.
module tb_vectorsum_stream_out;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int N  = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  logic          start1;
  logic          busy1;
  logic          done1;
  logic [AW-1:0] mem_rd_addr1;
  logic [DW-1:0] mem_dout1;
  logic [DW-1:0] out_data1;
  logic          out_valid1;
  logic          out_ready1;
  logic          out_last1;

  logic [DW-1:0] zmem [N];
  logic [DW-1:0] z1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Registered-read z memories.
  always @(posedge clock) begin
    mem_dout  <= (mem_rd_addr < AW'(N)) ? zmem[mem_rd_addr[5:0]] : 32'hBAD0_BAD0;
    mem_dout1 <= (mem_rd_addr1 == '0) ? z1 : 32'hBAD1_BAD1;
  end

  vectorsum_stream_out #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VECTOR_SIZE(N)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_rd_addr(mem_rd_addr), .mem_dout(mem_dout), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  vectorsum_stream_out #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VECTOR_SIZE(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .mem_rd_addr(mem_rd_addr1), .mem_dout(mem_dout1), .out_data(out_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_last(out_last1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One drain of the 64-word instance.
  // mode 0: ready high, 1: ready low for cycles 5..14, 2: ready 1,0,1,0..., 3: random ready.
  task automatic drain64(input int mode, input int start2_beat, input int reset_beat,
                         input bit start_in_done);
    int            k;
    int            acc;
    int            last_hs;
    int            done_cyc;
    bit            s2_done;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] exp_q [$];
    for (int i = 0; i < N; i++) exp_q.push_back(zmem[i]);
    acc = 0; last_hs = -1; done_cyc = -1; s2_done = 1'b0;
    prev_stall = 1'b0; prev_data = '0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    k = 0;
    while (1) begin
      start = 1'b0;
      if (done) begin
        done_cyc = k;
        break;
      end
      if (k > 2000) begin
        chk("timeout", 64'd0, 64'd1);
        break;
      end
      if ((reset_beat >= 0) && (acc == reset_beat)) begin
        out_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", mem_rd_addr, '0);
        repeat (3) begin
          @(negedge clock);
          chk("rst_no_done", done, 1'b0);
          chk("rst_stay_idle", busy, 1'b0);
        end
        return;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !((k >= 5) && (k <= 14));
        2:       out_ready = ((k % 2) == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      chk("busy_run", busy, 1'b1);
      if (k == 0) chk("first_addr", mem_rd_addr, '0);
      if (k < 2) chk("early_valid", out_valid, 1'b0);
      if ((mode == 0) && (k >= 2) && (acc < N)) chk("stream_gap", out_valid, 1'b1);
      chk("addr_window", (int'(mem_rd_addr) <= acc + 2), 1'b1);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, prev_data);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid && out_ready) begin
        if (acc < N) begin
          chk("beat_data", out_data, exp_q[acc]);
          chk("beat_last", out_last, (acc == N - 1));
        end else begin
          chk("extra_beat", acc, N - 1);
        end
        acc++;
        last_hs = k + 1;
      end
      if ((start2_beat >= 0) && (acc == start2_beat) && !s2_done) begin
        start = 1'b1;
        s2_done = 1'b1;
      end
      @(negedge clock);
      k++;
    end
    chk("beat_count", acc, N);
    chk("done_after_last", done_cyc, last_hs);
    if (mode == 0) chk("done_latency", done_cyc, N + 2);
    chk("busy_in_done", busy, 1'b0);
    if (start_in_done) start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("done_width", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_addr", mem_rd_addr, '0);
    chk("idle_valid", out_valid, 1'b0);
    @(negedge clock);
    chk("idle_stays", busy, 1'b0);
  endtask

  initial begin
    int k1;
    int beats1;
    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    out_ready = 1'b0; out_ready1 = 1'b0;
    for (int i = 0; i < N; i++) zmem[i] = 32'(3 * i + 1);
    z1 = 32'hDEAD_BEEF;
    repeat (3) @(negedge clock);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_addr", mem_rd_addr, '0);
    chk("reset_data", out_data, '0);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_last", out_last, 1'b0);
    chk("reset1_valid", out_valid1, 1'b0);
    reset = 1'b0;
    @(negedge clock);

    drain64(0, -1, -1, 1'b1);
    drain64(1, -1, -1, 1'b0);
    drain64(2, -1, -1, 1'b0);
    drain64(0, 20, -1, 1'b0);
    drain64(0, -1, 30, 1'b0);
    for (int i = 0; i < N; i++) zmem[i] = $urandom;
    drain64(3, -1, -1, 1'b0);

    // Single-word instance.
    out_ready1 = 1'b1;
    @(negedge clock);
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    k1 = 0; beats1 = 0;
    while (!done1 && (k1 <= 50)) begin
      chk("n1_addr", mem_rd_addr1, '0);
      if (out_valid1 && out_ready1) begin
        chk("n1_data", out_data1, 32'hDEAD_BEEF);
        chk("n1_last", out_last1, 1'b1);
        beats1++;
      end
      @(negedge clock);
      k1++;
    end
    chk("n1_beats", beats1, 1);
    chk("n1_done_latency", k1, 3);
    @(negedge clock);
    chk("n1_idle", busy1, 1'b0);

    // Start and reset in the same cycle.
    start = 1'b1; reset = 1'b1;
    @(negedge clock);
    start = 1'b0; reset = 1'b0;
    chk("sr_busy", busy, 1'b0);
    chk("sr_done", done, 1'b0);
    chk("sr_valid", out_valid, 1'b0);
    chk("sr_addr", mem_rd_addr, '0);
    chk("sr_data", out_data, '0);
    chk("sr_last", out_last, 1'b0);
    @(negedge clock);
    chk("sr_still_idle", busy, 1'b0);

    for (int i = 0; i < N; i++) zmem[i] = $urandom;
    drain64(3, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
